// File: rtl/axis_stream_monitor.sv
`default_nettype none
// ============================================================================
// Module   : axis_stream_monitor
// Purpose  : Passive multi-channel AXI4-Stream video monitor. For each of NCH
//            stream taps it reports frames per measurement window, lines per
//            frame, beats per line, backpressure stall cycles per window and a
//            sticky line-length mismatch flag. The block never drives any
//            handshake signal.
// Ports    : ACLK          - sole clock
//            ARESETN       - asynchronous, active-low reset
//            CLR           - synchronous clear of LEN_ERR and checker state
//            AXIS_TVALID   - per-channel TVALID   [NCH]
//            AXIS_TREADY   - per-channel TREADY   [NCH]
//            AXIS_TUSER    - per-channel SOF      [NCH]
//            AXIS_TLAST    - per-channel EOL      [NCH]
//            WINDOW_PULSE  - one-cycle strobe at the end of each window
//            FRAME_CNT     - SOFs in last window, ch i at [i*FCNT_W +: FCNT_W]
//            LINE_CNT      - lines in last completed frame
//            BEAT_CNT      - beats in last completed line (TLAST included)
//            STALL_CNT     - TVALID & !TREADY cycles in last window
//            LEN_ERR       - sticky line-length mismatch, one bit per channel
// Config   : AXIS_STREAM_MONITOR_STALL_EN - when defined the stall counters
//            are built; otherwise STALL_CNT is tied to zero.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module axis_stream_monitor #(
    parameter int          NCH           = 1,
    parameter int          FCNT_W        = 8,
    parameter int          LCNT_W        = 12,
    parameter int          BCNT_W        = 12,
    parameter int          SCNT_W        = 32,
    parameter int unsigned WINDOW_CYCLES = 100_000_000
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   CLR,
    input  logic [NCH-1:0]         AXIS_TVALID,
    input  logic [NCH-1:0]         AXIS_TREADY,
    input  logic [NCH-1:0]         AXIS_TUSER,
    input  logic [NCH-1:0]         AXIS_TLAST,
    output logic                   WINDOW_PULSE,
    output logic [NCH*FCNT_W-1:0]  FRAME_CNT,
    output logic [NCH*LCNT_W-1:0]  LINE_CNT,
    output logic [NCH*BCNT_W-1:0]  BEAT_CNT,
    output logic [NCH*SCNT_W-1:0]  STALL_CNT,
    output logic [NCH-1:0]         LEN_ERR
);

    typedef enum logic [1:0] {
        ST_WAIT_SOF   = 2'd0,
        ST_FIRST_LINE = 2'd1,
        ST_CHECK      = 2'd2
    } chk_state_e;

    localparam logic [31:0] C_WIN_LAST = 32'(WINDOW_CYCLES - 32'd1);

    // ------------------------------------------------------------------------
    // Shared window counter. The pulse flop is loaded with the comparison on
    // the next counter value so that it is high exactly while the counter
    // holds WINDOW_CYCLES-1, while still being a registered output.
    // ------------------------------------------------------------------------
    logic [31:0] win_q;
    logic [31:0] win_d;
    logic        pulse_q;
    logic        pulse_d;

    always_comb begin
        win_d   = (win_q == C_WIN_LAST) ? 32'd0 : win_q + 32'd1;
        pulse_d = (win_d == C_WIN_LAST);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            win_q   <= 32'd0;
            pulse_q <= 1'b0;
        end else begin
            win_q   <= win_d;
            pulse_q <= pulse_d;
        end
    end

    assign WINDOW_PULSE = pulse_q;

    // ------------------------------------------------------------------------
    // Per-channel measurement and checking
    // ------------------------------------------------------------------------
    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic              xfer;
        logic              sof;
        logic              eol;

        logic [BCNT_W-1:0] beat_q, beat_d, beat_inc;
        logic [BCNT_W-1:0] beat_out_q, beat_out_d;

        logic [LCNT_W-1:0] line_q, line_d, line_inc;
        logic [LCNT_W-1:0] line_out_q, line_out_d;
        logic              seen_sof_q, seen_sof_d;

        logic [FCNT_W-1:0] frame_q, frame_d, frame_inc;
        logic [FCNT_W-1:0] frame_out_q, frame_out_d;

        chk_state_e        state_q, state_d;
        logic [BCNT_W-1:0] chk_len_q, chk_len_d, chk_inc, chk_done;
        logic [BCNT_W-1:0] ref_q, ref_d;
        logic              err_q, err_d;

        assign xfer = AXIS_TVALID[ch] & AXIS_TREADY[ch];
        assign sof  = xfer & AXIS_TUSER[ch];
        assign eol  = xfer & AXIS_TLAST[ch];

        // Beat counter: the TLAST beat is folded into the latched value.
        always_comb begin
            beat_inc   = (beat_q == '1) ? beat_q : beat_q + BCNT_W'(1);
            beat_d     = beat_q;
            beat_out_d = beat_out_q;
            if (eol) begin
                beat_out_d = beat_inc;
                beat_d     = '0;
            end else if (xfer) begin
                beat_d     = beat_inc;
            end
        end

        // Line counter: a SOF closes the previous frame. Lines seen before
        // the first SOF after reset belong to an unmeasured partial frame,
        // so that first SOF reports zero.
        always_comb begin
            line_inc   = (line_q == '1) ? line_q : line_q + LCNT_W'(1);
            line_d     = line_q;
            line_out_d = line_out_q;
            seen_sof_d = seen_sof_q;
            if (sof) begin
                line_out_d = seen_sof_q ? line_q : '0;
                line_d     = eol ? LCNT_W'(1) : '0;
                seen_sof_d = 1'b1;
            end else if (eol) begin
                line_d     = line_inc;
            end
        end

        // Frame counter: a SOF in the pulse cycle seeds the next window so
        // no event falls between windows.
        always_comb begin
            frame_inc   = (frame_q == '1) ? frame_q : frame_q + FCNT_W'(1);
            frame_d     = frame_q;
            frame_out_d = frame_out_q;
            if (pulse_q) begin
                frame_out_d = frame_q;
                frame_d     = sof ? FCNT_W'(1) : '0;
            end else if (sof) begin
                frame_d     = frame_inc;
            end
        end

        // Length checker. It keeps its own line length so that the SOF beat
        // is always beat 1 of the first line, even if the stream was
        // truncated mid-line before that SOF.
        always_comb begin
            chk_inc   = (chk_len_q == '1) ? chk_len_q : chk_len_q + BCNT_W'(1);
            chk_done  = sof ? BCNT_W'(1) : chk_inc;
            chk_len_d = chk_len_q;
            if (xfer) begin
                chk_len_d = eol ? '0 : chk_done;
            end

            state_d = state_q;
            ref_d   = ref_q;
            err_d   = err_q;
            if (CLR) begin
                // Clear wins over a mismatch detected in the same cycle.
                state_d = ST_WAIT_SOF;
                ref_d   = '0;
                err_d   = 1'b0;
            end else if (sof) begin
                if (eol) begin
                    // Single-beat first line: reference taken immediately.
                    ref_d   = chk_done;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_FIRST_LINE;
                end
            end else if (eol) begin
                case (state_q)
                    ST_FIRST_LINE: begin
                        ref_d   = chk_done;
                        state_d = ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (chk_done != ref_q) begin
                            err_d = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
                beat_q      <= '0;
                beat_out_q  <= '0;
                line_q      <= '0;
                line_out_q  <= '0;
                seen_sof_q  <= 1'b0;
                frame_q     <= '0;
                frame_out_q <= '0;
                state_q     <= ST_WAIT_SOF;
                chk_len_q   <= '0;
                ref_q       <= '0;
                err_q       <= 1'b0;
            end else begin
                beat_q      <= beat_d;
                beat_out_q  <= beat_out_d;
                line_q      <= line_d;
                line_out_q  <= line_out_d;
                seen_sof_q  <= seen_sof_d;
                frame_q     <= frame_d;
                frame_out_q <= frame_out_d;
                state_q     <= state_d;
                chk_len_q   <= chk_len_d;
                ref_q       <= ref_d;
                err_q       <= err_d;
            end
        end

        assign BEAT_CNT[ch*BCNT_W +: BCNT_W]  = beat_out_q;
        assign LINE_CNT[ch*LCNT_W +: LCNT_W]  = line_out_q;
        assign FRAME_CNT[ch*FCNT_W +: FCNT_W] = frame_out_q;
        assign LEN_ERR[ch]                    = err_q;

`ifdef AXIS_STREAM_MONITOR_STALL_EN
        logic              stall;
        logic [SCNT_W-1:0] stall_q, stall_d, stall_inc;
        logic [SCNT_W-1:0] stall_out_q, stall_out_d;

        assign stall = AXIS_TVALID[ch] & ~AXIS_TREADY[ch];

        // Same latch/restart rule as the frame counter.
        always_comb begin
            stall_inc   = (stall_q == '1) ? stall_q : stall_q + SCNT_W'(1);
            stall_d     = stall_q;
            stall_out_d = stall_out_q;
            if (pulse_q) begin
                stall_out_d = stall_q;
                stall_d     = stall ? SCNT_W'(1) : '0;
            end else if (stall) begin
                stall_d     = stall_inc;
            end
        end

        always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
                stall_q     <= '0;
                stall_out_q <= '0;
            end else begin
                stall_q     <= stall_d;
                stall_out_q <= stall_out_d;
            end
        end

        assign STALL_CNT[ch*SCNT_W +: SCNT_W] = stall_out_q;
`else
        assign STALL_CNT[ch*SCNT_W +: SCNT_W] = '0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_stream_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_stream_monitor
// Purpose  : Self-checking bench for axis_stream_monitor (NCH=2, BCNT_W=8,
//            WINDOW_CYCLES=1000). Directed stimulus pushes hand-computed
//            expectations into queues; a monitor on the falling clock edge
//            pops and compares them against the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_stream_monitor;

    localparam int NCH    = 2;
    localparam int FCNT_W = 8;
    localparam int LCNT_W = 12;
    localparam int BCNT_W = 8;
    localparam int SCNT_W = 32;
    localparam int WIN    = 1000;

    localparam int K_BEAT  = 0;
    localparam int K_LINE  = 1;
    localparam int K_ERR   = 2;
    localparam int K_ERRV  = 3;
    localparam int K_FRAME = 4;
    localparam int K_STALL = 5;
    localparam int K_PULSE = 6;

`ifdef AXIS_STREAM_MONITOR_STALL_EN
    localparam int STALL_EXP = 37;
`else
    localparam int STALL_EXP = 0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  clr = 1'b0;
    logic [NCH-1:0]        tvalid = '0;
    logic [NCH-1:0]        tready = '1;
    logic [NCH-1:0]        tuser = '0;
    logic [NCH-1:0]        tlast = '0;
    logic                  WINDOW_PULSE;
    logic [NCH*FCNT_W-1:0] FRAME_CNT;
    logic [NCH*LCNT_W-1:0] LINE_CNT;
    logic [NCH*BCNT_W-1:0] BEAT_CNT;
    logic [NCH*SCNT_W-1:0] STALL_CNT;
    logic [NCH-1:0]        LEN_ERR;

    int n_tests = 0;
    int n_fail  = 0;

    axis_stream_monitor #(
        .NCH           (NCH),
        .FCNT_W        (FCNT_W),
        .LCNT_W        (LCNT_W),
        .BCNT_W        (BCNT_W),
        .SCNT_W        (SCNT_W),
        .WINDOW_CYCLES (WIN)
    ) u_dut (
        .ACLK         (clk),
        .ARESETN      (rst_n),
        .CLR          (clr),
        .AXIS_TVALID  (tvalid),
        .AXIS_TREADY  (tready),
        .AXIS_TUSER   (tuser),
        .AXIS_TLAST   (tlast),
        .WINDOW_PULSE (WINDOW_PULSE),
        .FRAME_CNT    (FRAME_CNT),
        .LINE_CNT     (LINE_CNT),
        .BEAT_CNT     (BEAT_CNT),
        .STALL_CNT    (STALL_CNT),
        .LEN_ERR      (LEN_ERR)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          ch;
        logic [31:0] req;
    } chk_t;

    typedef struct {
        int          ch;
        logic [31:0] frame;
        logic [31:0] stall;
    } win_t;

    chk_t chk_q[$];
    win_t win_q[$];

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic logic [31:0] actual(input int kind, input int ch);
        case (kind)
            K_BEAT:  return 32'(BEAT_CNT[ch*BCNT_W +: BCNT_W]);
            K_LINE:  return 32'(LINE_CNT[ch*LCNT_W +: LCNT_W]);
            K_ERR:   return 32'(LEN_ERR[ch]);
            K_ERRV:  return 32'(LEN_ERR);
            K_FRAME: return 32'(FRAME_CNT[ch*FCNT_W +: FCNT_W]);
            K_STALL: return 32'(STALL_CNT[ch*SCNT_W +: SCNT_W]);
            K_PULSE: return 32'(WINDOW_PULSE);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic string kname(input int kind, input int ch);
        case (kind)
            K_BEAT:  return $sformatf("beat_cnt[%0d]", ch);
            K_LINE:  return $sformatf("line_cnt[%0d]", ch);
            K_ERR:   return $sformatf("len_err[%0d]", ch);
            K_ERRV:  return "len_err_vec";
            K_FRAME: return $sformatf("frame_cnt[%0d]", ch);
            K_STALL: return $sformatf("stall_cnt[%0d]", ch);
            K_PULSE: return "window_pulse";
            default: return "unknown";
        endcase
    endfunction

    task automatic push_chk(input int kind, input int ch, input logic [31:0] req);
        chk_t e;
        e.kind = kind;
        e.ch   = ch;
        e.req  = req;
        chk_q.push_back(e);
    endtask

    task automatic push_win(input int ch, input logic [31:0] frame, input logic [31:0] stall);
        win_t w;
        w.ch    = ch;
        w.frame = frame;
        w.stall = stall;
        win_q.push_back(w);
    endtask

    task automatic push_all_zero();
        for (int c = 0; c < NCH; c++) begin
            push_chk(K_BEAT, c, 0);
            push_chk(K_LINE, c, 0);
            push_chk(K_ERR, c, 0);
            push_chk(K_FRAME, c, 0);
            push_chk(K_STALL, c, 0);
        end
        push_chk(K_ERRV, 0, 0);
        push_chk(K_PULSE, 0, 0);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: cycles since reset release, per-cycle checks, window checks
    // ------------------------------------------------------------------------
    int   since_rel = 0;
    logic win_pending = 1'b0;
    chk_t mon_e;
    win_t mon_w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) since_rel <= 0;
        else        since_rel <= since_rel + 1;
    end

    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            mon_e = chk_q.pop_front();
            check(kname(mon_e.kind, mon_e.ch), actual(mon_e.kind, mon_e.ch), mon_e.req);
        end
        if (win_pending) begin
            while (win_q.size() > 0) begin
                mon_w = win_q.pop_front();
                check(kname(K_FRAME, mon_w.ch), actual(K_FRAME, mon_w.ch), mon_w.frame);
                check(kname(K_STALL, mon_w.ch), actual(K_STALL, mon_w.ch), mon_w.stall);
            end
        end
        win_pending = (WINDOW_PULSE === 1'b1);
        if (WINDOW_PULSE === 1'b1) begin
            check("pulse_phase", 32'(since_rel % WIN), 32'(WIN - 1));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int ch, input int n, input bit sof, input bit clr_last = 1'b0);
        for (int b = 0; b < n; b++) begin
            tvalid[ch] = 1'b1;
            tready[ch] = 1'b1;
            tuser[ch]  = sof && (b == 0);
            tlast[ch]  = (b == n - 1);
            clr        = clr_last && (b == n - 1);
            step();
        end
        tvalid[ch] = 1'b0;
        tuser[ch]  = 1'b0;
        tlast[ch]  = 1'b0;
        clr        = 1'b0;
    endtask

    task automatic wait_pulse();
        int n = 0;
        step();
        while (WINDOW_PULSE !== 1'b1 && n < 2100) begin
            step();
            n++;
        end
        if (WINDOW_PULSE !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL window_pulse_timeout: actual no pulse in %0d cycles required pulse", n);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        // Reset state
        repeat (3) step();
        push_all_zero();
        step();
        rst_n = 1'b1;

        // Frames of 4 lines x 16 beats, back to back
        send_line(0, 16, 1'b1);
        repeat (3) send_line(0, 16, 1'b0);
        push_chk(K_BEAT, 0, 16);
        push_chk(K_LINE, 0, 0);
        push_chk(K_ERR, 0, 0);
        send_line(0, 16, 1'b1);
        push_chk(K_LINE, 0, 4);
        push_chk(K_BEAT, 0, 16);
        push_chk(K_ERR, 0, 0);
        repeat (3) send_line(0, 16, 1'b0);

        // Third line short: sticky error
        send_line(0, 16, 1'b1);
        push_chk(K_LINE, 0, 4);
        send_line(0, 16, 1'b0);
        push_chk(K_ERR, 0, 0);
        send_line(0, 15, 1'b0);
        push_chk(K_ERR, 0, 1);
        push_chk(K_BEAT, 0, 15);
        send_line(0, 16, 1'b0);
        push_chk(K_ERR, 0, 1);
        send_line(0, 16, 1'b1);
        push_chk(K_LINE, 0, 4);
        push_chk(K_ERR, 0, 1);
        repeat (3) send_line(0, 16, 1'b0);

        // CLR clears the flag; lines before the next SOF are not checked
        clr = 1'b1;
        step();
        clr = 1'b0;
        push_chk(K_ERRV, 0, 0);
        send_line(0, 10, 1'b0);
        push_chk(K_ERR, 0, 0);
        push_chk(K_BEAT, 0, 10);

        // New frame with a new reference length
        send_line(0, 8, 1'b1);
        push_chk(K_LINE, 0, 5);
        repeat (2) send_line(0, 8, 1'b0);
        push_chk(K_ERR, 0, 0);
        push_chk(K_BEAT, 0, 8);

        // Mismatching eol with CLR in the same cycle: CLR wins
        send_line(0, 7, 1'b0, 1'b1);
        push_chk(K_ERR, 0, 0);
        push_chk(K_BEAT, 0, 7);

        // Channel 1 errors only
        send_line(1, 5, 1'b1);
        send_line(1, 5, 1'b0);
        send_line(1, 6, 1'b0);
        push_chk(K_ERRV, 0, 2);
        push_chk(K_BEAT, 1, 6);
        push_chk(K_LINE, 1, 0);
        push_chk(K_BEAT, 0, 7);
        push_chk(K_LINE, 0, 5);

        // 300-beat line saturates the 8-bit beat count
        send_line(0, 300, 1'b1);
        push_chk(K_BEAT, 0, 255);
        push_chk(K_LINE, 0, 4);
        push_chk(K_ERRV, 0, 2);

        // One window: 5 SOFs and 37 stall cycles on channel 0
        wait_pulse();
        step();
        repeat (5) send_line(0, 4, 1'b1);
        push_chk(K_LINE, 0, 1);
        push_chk(K_BEAT, 0, 4);
        tvalid[0] = 1'b1;
        tready[0] = 1'b0;
        repeat (37) step();
        tvalid[0] = 1'b0;
        tready[0] = 1'b1;
        push_win(0, 5, STALL_EXP);
        push_win(1, 0, 0);
        wait_pulse();
        repeat (2) step();

        // SOF coincident with WINDOW_PULSE belongs to the next window
        repeat (2) send_line(0, 4, 1'b1);
        push_win(0, 2, 0);
        push_win(1, 0, 0);
        wait_pulse();
        tvalid[0] = 1'b1;
        tready[0] = 1'b1;
        tuser[0]  = 1'b1;
        tlast[0]  = 1'b1;
        step();
        tvalid[0] = 1'b0;
        tuser[0]  = 1'b0;
        tlast[0]  = 1'b0;
        repeat (3) step();
        send_line(0, 4, 1'b1);
        push_chk(K_LINE, 0, 1);
        push_win(0, 2, 0);
        push_win(1, 0, 0);
        wait_pulse();
        repeat (2) step();

        // Asynchronous reset mid-line
        for (int b = 0; b < 5; b++) begin
            tvalid[0] = 1'b1;
            tuser[0]  = (b == 0);
            tlast[0]  = 1'b0;
            step();
        end
        rst_n = 1'b0;
        push_all_zero();
        tvalid[0] = 1'b0;
        tuser[0]  = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) send_line(0, 4, 1'b0);
        send_line(0, 4, 1'b1);
        push_chk(K_LINE, 0, 0);
        push_chk(K_BEAT, 0, 4);
        push_chk(K_ERR, 0, 0);
        send_line(0, 4, 1'b0);
        send_line(0, 4, 1'b1);
        push_chk(K_LINE, 0, 2);

        repeat (3) step();
        check("scoreboard_drain", 32'(chk_q.size() + win_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
